// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding,
// per-stage stall/flush control bundle and common widths.
package pipeline_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned CNT_W      = 32;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_REDIRECT = 2'd2
    } hazard_state_e;

    // Control bundle driven into the PC and the pipeline registers.
    typedef struct packed {
        logic pc_stall;
        logic ifid_stall;
        logic idex_stall;
        logic exmem_stall;
        logic ifid_flush;
        logic idex_flush;
        logic memwb_flush;
        logic redirect_take;
    } PipeCtrl_t;

    // ID reads a register that the load in EX is about to write (x0 excluded).
    function automatic logic is_load_use(
        input logic                  ex_is_load,
        input logic [REG_ADDR_W-1:0] ex_rd,
        input logic                  use_rs1,
        input logic [REG_ADDR_W-1:0] rs1,
        input logic                  use_rs2,
        input logic [REG_ADDR_W-1:0] rs2
    );
        return ex_is_load && (ex_rd != '0) &&
               ((use_rs1 && (rs1 == ex_rd)) || (use_rs2 && (rs2 == ex_rd)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter.
//   clk_i   : clock
//   rst_i   : synchronous active-high clear
//   inc_i   : count one event this cycle
//   count_o : current count, sticks at all-ones
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_o <= '0;
        end else if (inc_i && (count_o != {WIDTH{1'b1}})) begin
            count_o <= count_o + WIDTH'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: resolves memory waits, redirects, load-use
// hazards and fetch waits into stall/flush controls, and counts stall and
// redirect cycles.
//   clk_i, rst_i             : clock, synchronous active-high reset
//   id_rs1_i/id_rs2_i        : ID source registers, id_use_rs*_i qualify them
//   ex_rd_i, ex_is_load_i    : EX destination and load flag
//   ex_redirect_i            : EX branch/jump changes the PC
//   mem_busy_i, if_busy_i    : data / instruction memory not ready
//   *_stall_o, *_flush_o     : per-stage hold / bubble controls
//   redirect_take_o          : PC mux takes the branch target
//   stall_cycles_o           : cycles with pc_stall_o=1 (saturating)
//   redirect_cnt_o           : cycles with redirect_take_o=1 (saturating)
module hazard_ctrl
    import pipeline_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic        id_use_rs1_i,
    input  logic        id_use_rs2_i,
    input  logic [4:0]  ex_rd_i,
    input  logic        ex_is_load_i,
    input  logic        ex_redirect_i,
    input  logic        mem_busy_i,
    input  logic        if_busy_i,
    output logic        pc_stall_o,
    output logic        ifid_stall_o,
    output logic        idex_stall_o,
    output logic        exmem_stall_o,
    output logic        ifid_flush_o,
    output logic        idex_flush_o,
    output logic        memwb_flush_o,
    output logic        redirect_take_o,
    output logic [31:0] stall_cycles_o,
    output logic [31:0] redirect_cnt_o
);

    hazard_state_e state_q;
    hazard_state_e state_d;
    PipeCtrl_t     ctrl;
    logic          load_use;

    assign load_use = is_load_use(ex_is_load_i, ex_rd_i, id_use_rs1_i, id_rs1_i,
                                  id_use_rs2_i, id_rs2_i);

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: every state shares the same exit rule, memory wait first.
    always_comb begin
        state_d = state_q;
        if (mem_busy_i) begin
            state_d = ST_MEM_WAIT;
        end else if (ctrl.redirect_take) begin
            state_d = ST_REDIRECT;
        end else begin
            state_d = ST_RUN;
        end
    end

    // Outputs: one event wins by priority; REDIRECT additionally squashes
    // the stale word fetched from the old PC.
    always_comb begin
        ctrl = '0;
        if (!rst_i) begin
            if (mem_busy_i) begin
                ctrl.pc_stall    = 1'b1;
                ctrl.ifid_stall  = 1'b1;
                ctrl.idex_stall  = 1'b1;
                ctrl.exmem_stall = 1'b1;
                ctrl.memwb_flush = 1'b1;
            end else if (ex_redirect_i) begin
                ctrl.redirect_take = 1'b1;
                ctrl.ifid_flush    = 1'b1;
                ctrl.idex_flush    = 1'b1;
            end else if (load_use) begin
                ctrl.pc_stall   = 1'b1;
                ctrl.ifid_stall = 1'b1;
                ctrl.idex_flush = 1'b1;
            end else if (if_busy_i) begin
                ctrl.pc_stall   = 1'b1;
                ctrl.ifid_flush = 1'b1;
            end
            if (state_q == ST_REDIRECT) begin
                ctrl.ifid_flush = 1'b1;
            end
        end
    end

    assign pc_stall_o      = ctrl.pc_stall;
    assign ifid_stall_o    = ctrl.ifid_stall;
    assign idex_stall_o    = ctrl.idex_stall;
    assign exmem_stall_o   = ctrl.exmem_stall;
    assign ifid_flush_o    = ctrl.ifid_flush;
    assign idex_flush_o    = ctrl.idex_flush;
    assign memwb_flush_o   = ctrl.memwb_flush;
    assign redirect_take_o = ctrl.redirect_take;

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (ctrl.pc_stall),
        .count_o (stall_cycles_o)
    );

    sat_counter #(.WIDTH(CNT_W)) u_redirect_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (ctrl.redirect_take),
        .count_o (redirect_cnt_o)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios plus random traffic,
// expectations from a behavioural model, checked by an independent monitor.
module tb_hazard_ctrl;
    import pipeline_pkg::*;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1, rs2, rd;
    logic        use1, use2, is_load, redir, mem_busy, if_busy;
    logic        pc_stall, ifid_stall, idex_stall, exmem_stall;
    logic        ifid_flush, idex_flush, memwb_flush, redirect_take;
    logic [31:0] stall_cycles, redirect_cnt;
    logic [2:0]  sat3;

    hazard_ctrl dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .id_rs1_i        (rs1),
        .id_rs2_i        (rs2),
        .id_use_rs1_i    (use1),
        .id_use_rs2_i    (use2),
        .ex_rd_i         (rd),
        .ex_is_load_i    (is_load),
        .ex_redirect_i   (redir),
        .mem_busy_i      (mem_busy),
        .if_busy_i       (if_busy),
        .pc_stall_o      (pc_stall),
        .ifid_stall_o    (ifid_stall),
        .idex_stall_o    (idex_stall),
        .exmem_stall_o   (exmem_stall),
        .ifid_flush_o    (ifid_flush),
        .idex_flush_o    (idex_flush),
        .memwb_flush_o   (memwb_flush),
        .redirect_take_o (redirect_take),
        .stall_cycles_o  (stall_cycles),
        .redirect_cnt_o  (redirect_cnt)
    );

    // Narrow copy of the counter so saturation is reachable in a short run.
    sat_counter #(.WIDTH(3)) u_sat3 (
        .clk_i   (clk),
        .rst_i   (rst),
        .inc_i   (pc_stall),
        .count_o (sat3)
    );

    typedef struct {
        logic [7:0]  ctrl;   // {pc,ifid_s,idex_s,exmem_s,ifid_f,idex_f,memwb_f,take}
        logic [31:0] stall;
        logic [31:0] redir;
        logic [2:0]  sat3;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Model state: counts as plain integers, and whether last cycle took a redirect.
    longint m_stall = 0;
    longint m_redir = 0;
    longint m_sat3  = 0;
    bit     m_prev_take = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint clip(input longint v, input longint cap);
        return (v > cap) ? cap : v;
    endfunction

    task automatic step(input bit r, input bit ld, input int d, input int s1, input bit u1,
                        input int s2, input bit u2, input bit br, input bit mb, input bit ib);
        exp_t e;
        bit   lu;
        bit   p, is_, es_, ms_, ff, xf, wf, tk;
        rst = r; is_load = ld; rd = 5'(d); rs1 = 5'(s1); use1 = u1;
        rs2 = 5'(s2); use2 = u2; redir = br; mem_busy = mb; if_busy = ib;
        lu = ld && (d != 0) && ((u1 && s1 == d) || (u2 && s2 == d));
        {p, is_, es_, ms_, ff, xf, wf, tk} = '0;
        if (!r) begin
            case (1'b1)
                mb:      {p, is_, es_, ms_, wf} = 5'b11111;
                br:      {tk, ff, xf}           = 3'b111;
                lu:      {p, is_, xf}           = 3'b111;
                ib:      {p, ff}                = 2'b11;
                default: ;
            endcase
            if (m_prev_take) ff = 1'b1;
        end
        e.ctrl  = {p, is_, es_, ms_, ff, xf, wf, tk};
        e.stall = 32'(m_stall);
        e.redir = 32'(m_redir);
        e.sat3  = 3'(m_sat3);
        e.cyc   = cyc;
        exp_q.push_back(e);
        if (r) begin
            m_stall = 0; m_redir = 0; m_sat3 = 0;
        end else begin
            m_stall = clip(m_stall + longint'(p), 64'hFFFF_FFFF);
            m_redir = clip(m_redir + longint'(tk), 64'hFFFF_FFFF);
            m_sat3  = clip(m_sat3 + longint'(p), 7);
        end
        m_prev_take = tk;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: outputs are presented every cycle; compare at mid-cycle.
    initial begin
        exp_t        e;
        logic [7:0]  act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {pc_stall, ifid_stall, idex_stall, exmem_stall,
                       ifid_flush, idex_flush, memwb_flush, redirect_take};
                checks++;
                if (act !== e.ctrl) begin
                    errors++;
                    $display("FAIL ctrl cyc=%0d got=%b want=%b", e.cyc, act, e.ctrl);
                end
                checks++;
                if (stall_cycles !== e.stall) begin
                    errors++;
                    $display("FAIL stall_cycles cyc=%0d got=%0h want=%0h", e.cyc, stall_cycles, e.stall);
                end
                checks++;
                if (redirect_cnt !== e.redir) begin
                    errors++;
                    $display("FAIL redirect_cnt cyc=%0d got=%0h want=%0h", e.cyc, redirect_cnt, e.redir);
                end
                checks++;
                if (sat3 !== e.sat3) begin
                    errors++;
                    $display("FAIL sat3 cyc=%0d got=%0d want=%0d", e.cyc, sat3, e.sat3);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; is_load = 0; rd = 0; rs1 = 0; rs2 = 0; use1 = 0; use2 = 0;
        redir = 0; mem_busy = 0; if_busy = 0;
        repeat (2) @(posedge clk);
        #1;
        // Reset with every hazard input active: outputs must be quiet.
        step(1, 1, 5, 5, 1, 5, 1, 1, 1, 1);
        idle(2);
        // Load-use on rs1, then on rs2.
        step(0, 1, 5, 5, 1, 0, 0, 0, 0, 0);
        idle(1);
        step(0, 1, 7, 1, 0, 7, 1, 0, 0, 0);
        // Load to x0 never stalls.
        step(0, 1, 0, 0, 1, 0, 1, 0, 0, 0);
        idle(1);
        // Single redirect in RUN, then the follow-up squash cycle.
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(2);
        // Redirect held across a 3-cycle memory wait.
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        // Memory wait in the REDIRECT cycle, and fetch wait alone.
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 1, 3, 3, 1, 0, 0, 0, 0, 1);
        // Reset in the middle of a memory wait with a redirect pending.
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(1);
        // Reset during the REDIRECT cycle drops the squash.
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        // Long stall to push the narrow counter into saturation.
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(1);
        // Random traffic over small register numbers to provoke matches.
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(63) == 0), $urandom_range(1), $urandom_range(3),
                 $urandom_range(3), $urandom_range(1), $urandom_range(3), $urandom_range(1),
                 ($urandom_range(3) == 0), ($urandom_range(4) == 0), ($urandom_range(3) == 0));
        end
        idle(1);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset. Ports: clk_i, rst_i.
REQ-002 clk_i  in  1  clock; every state element updates on its rising edge.
REQ-003 rst_i  in  1  synchronous active-high reset.
REQ-004 id_rs1_i, id_rs2_i  in  5 each  source registers of the instruction in ID.
REQ-005 id_use_rs1_i, id_use_rs2_i  in  1 each  the ID instruction reads rs1 / rs2.
REQ-006 ex_rd_i  in  5  destination of the instruction in EX; ex_is_load_i  in  1  EX holds a load.
REQ-007 ex_redirect_i  in  1  branch or jump in EX changes the PC.
REQ-008 mem_busy_i  in  1  data memory has not completed the MEM access.
REQ-009 if_busy_i  in  1  instruction memory has no valid data this cycle.
REQ-010 pc_stall_o  out  1  hold the PC.
REQ-011 ifid_stall_o, idex_stall_o, exmem_stall_o  out  1 each  hold that pipeline register.
REQ-012 ifid_flush_o, idex_flush_o, memwb_flush_o  out  1 each  load a bubble (all zero) into that register.
REQ-013 redirect_take_o  out  1  the PC mux loads the branch target this cycle.
REQ-014 stall_cycles_o  out  32  count of cycles with pc_stall_o=1.
REQ-015 redirect_cnt_o  out  32  count of cycles with redirect_take_o=1.

Function
REQ-016 SHALL implement states RUN, MEM_WAIT and REDIRECT; outputs are combinational from state and inputs.
REQ-017 Event priority SHALL be mem_busy_i > ex_redirect_i > load-use > if_busy_i.
REQ-018 Load-use SHALL mean ex_is_load_i & ex_rd_i!=0 & ((id_use_rs1_i & rs1==rd) | (id_use_rs2_i & rs2==rd)).
REQ-019 mem_busy_i=1 (any state) SHALL assert pc_stall, ifid_stall, idex_stall, exmem_stall and memwb_flush, and force redirect_take_o=0.
REQ-020 With ex_redirect_i=1 and mem_busy_i=0, redirect_take_o, ifid_flush_o and idex_flush_o SHALL be 1 and pc_stall_o 0.
REQ-021 Load-use without a higher-priority event SHALL assert pc_stall, ifid_stall and idex_flush for exactly one cycle.
REQ-022 if_busy_i alone SHALL assert pc_stall_o and ifid_flush_o.
REQ-023 In REDIRECT, ifid_flush_o SHALL be 1 regardless of other inputs, which discards the stale synchronous-fetch word; the other outputs follow REQ-019..022.
REQ-024 Transitions: RUN->MEM_WAIT when mem_busy; RUN->REDIRECT when redirect_take_o; else stay in RUN.
REQ-025 MEM_WAIT SHALL stay while mem_busy; on release it goes to REDIRECT if redirect_take_o, otherwise to RUN.
REQ-026 REDIRECT SHALL last one cycle and then go to MEM_WAIT if mem_busy, REDIRECT if redirect_take_o, otherwise RUN.
REQ-027 A redirect held during MEM_WAIT SHALL be taken in the first cycle after mem_busy_i falls, never earlier.
REQ-028 Both counters SHALL increment by 1 per qualifying cycle and saturate at 0xFFFF_FFFF.

Reset
REQ-029 While rst_i=1, all stall, flush and redirect_take outputs SHALL be 0, whatever the inputs.
REQ-030 While rst_i=1, state SHALL go to RUN and both counters to 0 on the next edge.
REQ-031 A reset in MEM_WAIT or REDIRECT SHALL abandon the state; no pending redirect survives.

Structure
REQ-032 pipeline_pkg SHALL hold the hazard_state_e enum and the PipeCtrl_t struct (stall/flush bits per stage).
REQ-033 The two counters SHALL be instances of one sub-module, sat_counter (param WIDTH=32, inc_i, count_o).

Verification
REQ-034 Load-use: ex_is_load=1, ex_rd=5, id_rs1=5, use_rs1=1 for 1 cycle -> pc_stall=ifid_stall=idex_flush=1 for 1 cycle; stall_cycles_o=1.
REQ-035 x0 load: ex_rd=0, id_rs1=0 -> no stall and no flush; counters unchanged.
REQ-036 Redirect: ex_redirect=1 for 1 cycle in RUN -> redirect_take=ifid_flush=idex_flush=1 that cycle, ifid_flush=1 the next cycle, then RUN; redirect_cnt_o=1.
REQ-037 MEM wait with redirect: mem_busy=1 for 3 cycles while ex_redirect=1 -> 3 cycles with exmem_stall=1, memwb_flush=1 and redirect_take=0; redirect_take=1 on cycle 4; stall_cycles_o=3.
REQ-038 Reset mid-MEM_WAIT: rst_i pulse at cycle 2 of a mem_busy window -> outputs 0 during reset, state RUN, counters 0.
REQ-039 Saturation: force stall_cycles to 0xFFFF_FFFE, then 3 stall cycles -> stall_cycles_o holds 0xFFFF_FFFF.
